// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

   // Default dividend/quotient width and divisor/remainder width.
   localparam int DIV_DIVIDEND_W = 8;
   localparam int DIV_DIVISOR_W  = 4;

   // Bit-counter width for a given dividend width.
   // The result is never narrower than one bit, so a 1-bit dividend still gets a usable counter.
   function automatic int div_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DIV_CNT_W = div_cnt_w(DIV_DIVIDEND_W);

   // Divider control states.
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step.
// The partial remainder takes in the next dividend bit. The divisor is then subtracted
// whenever it fits, and that decision becomes the quotient bit.
module div_step #(
   parameter int DIVISOR_W = 4
) (
   input  logic [DIVISOR_W:0]   rem,
   input  logic                 q_msb,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W:0]   rem_next,
   output logic                 q_bit
);

   logic [DIVISOR_W:0] shifted;
   logic [DIVISOR_W:0] divisor_ext;

   // Shift in the dividend bit, then do a trial subtract and keep the result only when it does not go negative.
   always_comb begin
      shifted     = {rem[DIVISOR_W-1:0], q_msb};
      divisor_ext = {1'b0, divisor};
      q_bit       = (shifted >= divisor_ext);
      rem_next    = q_bit ? (shifted - divisor_ext) : shifted;
   end

endmodule

// File: rtl/seq_div.sv
// Iterative restoring divider: unsigned dividend / divisor -> quotient + remainder.
// It produces one quotient bit per clock and uses valid/ready handshakes on both sides.
// A zero divisor skips the iteration and returns all-ones / 0 with div_by_zero set.
module seq_div
   import div_pkg::*;
#(
   parameter int DIVIDEND_W = DIV_DIVIDEND_W,
   parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);

   localparam int CNT_W = div_cnt_w(DIVIDEND_W);

   div_state_e            state_reg, state_next;
   logic [DIVISOR_W-1:0]  divisor_reg;
   logic [DIVIDEND_W-1:0] q_reg, q_next;
   logic [DIVISOR_W:0]    rem_reg, rem_next;
   logic [CNT_W-1:0]      count_reg;
   logic                  step_q_bit;

   logic [DIVIDEND_W-1:0] quotient_reg;
   logic [DIVISOR_W-1:0]  remainder_reg;
   logic                  div_by_zero_reg;

   logic accept;
   logic out_fire;
   logic last_step;
   logic zero_div;

   assign in_ready    = (state_reg == IDLE);
   assign out_valid   = (state_reg == DONE);
   assign accept      = in_valid && in_ready;
   assign out_fire    = out_valid && out_ready;
   assign zero_div    = (divisor == '0);
   assign last_step   = (count_reg == CNT_W'(DIVIDEND_W - 1));

   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = div_by_zero_reg;

   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .rem      (rem_reg),
      .q_msb    (q_reg[DIVIDEND_W-1]),
      .divisor  (divisor_reg),
      .rem_next (rem_next),
      .q_bit    (step_q_bit)
   );

   // The quotient register shifts left each step; the new quotient bit enters at the LSB.
   assign q_next = {q_reg[DIVIDEND_W-2:0], step_q_bit};

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic. A zero divisor goes straight to DONE.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = zero_div ? DONE : CALC;
            end
         end
         CALC: begin
            if (last_step) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_fire) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Iteration datapath.
   // Operands are loaded on accept and advanced one bit per CALC cycle.
   // After accept the inputs are never looked at again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divisor_reg <= '0;
         q_reg       <= '0;
         rem_reg     <= '0;
         count_reg   <= '0;
      end else if (accept) begin
         divisor_reg <= divisor;
         q_reg       <= dividend;
         rem_reg     <= '0;
         count_reg   <= '0;
      end else if (state_reg == CALC) begin
         q_reg       <= q_next;
         rem_reg     <= rem_next;
         count_reg   <= count_reg + CNT_W'(1);
      end
   end

   // Result registers.
   // They load only when a result is produced, so they hold through DONE and after the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quotient_reg    <= '0;
         remainder_reg   <= '0;
         div_by_zero_reg <= 1'b0;
      end else if (accept && zero_div) begin
         quotient_reg    <= '1;
         remainder_reg   <= '0;
         div_by_zero_reg <= 1'b1;
      end else if ((state_reg == CALC) && last_step) begin
         quotient_reg    <= q_next;
         remainder_reg   <= rem_next[DIVISOR_W-1:0];
         div_by_zero_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div.
// It covers a directed vector table, a back-pressure sequence, an abort by reset,
// a multiply loopback, and random operations.
module tb_seq_div;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int n_checks = 0;
   int n_fail   = 0;

   seq_div dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
      int         lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Clock edge, then settle before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one full operation.
   // lat is the number of edges after the accept edge until out_valid is seen (-1 on timeout).
   task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL in_ready_timeout: got 0, expected 1");
      end
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      in_valid = 1'b0;
      dividend = 8'hXX;
      divisor  = 4'hX;
      lat = 0;
      while (!out_valid && lat < 50) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
      q = quotient;
      r = remainder;
      z = div_by_zero;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic [7:0] q;
      logic [3:0] r;
      logic       z;
      int         lat;
      logic [7:0] ra;
      logic [3:0] rb;
      logic [7:0] eq;
      logic [3:0] er;
      logic       ez;

      // Directed vectors.
      // A zero divisor shows its result straight after the accept edge.
      // A normal divide takes 8 more edges.
      vecs[0] = '{a: 8'd200, b: 4'd13, q: 8'd15,  r: 4'd5, z: 1'b0, lat: 8};
      vecs[1] = '{a: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0, z: 1'b0, lat: 8};
      vecs[2] = '{a: 8'd7,   b: 4'd9,  q: 8'd0,   r: 4'd7, z: 1'b0, lat: 8};
      vecs[3] = '{a: 8'd15,  b: 4'd15, q: 8'd1,   r: 4'd0, z: 1'b0, lat: 8};
      vecs[4] = '{a: 8'd100, b: 4'd0,  q: 8'hFF,  r: 4'd0, z: 1'b1, lat: 0};
      vecs[5] = '{a: 8'd0,   b: 4'd5,  q: 8'd0,   r: 4'd0, z: 1'b0, lat: 8};
      vecs[6] = '{a: 8'd255, b: 4'd15, q: 8'd17,  r: 4'd0, z: 1'b0, lat: 8};
      vecs[7] = '{a: 8'd128, b: 4'd3,  q: 8'd42,  r: 4'd2, z: 1'b0, lat: 8};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", 32'(out_valid), 32'd0);
      check("reset_quotient", 32'(quotient), 32'd0);
      check("reset_remainder", 32'(remainder), 32'd0);
      check("reset_div_by_zero", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // Table-driven vectors.
      for (int i = 0; i < 8; i++) begin
         do_op(vecs[i].a, vecs[i].b, q, r, z, lat);
         $display("vec %0d: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", i, vecs[i].a, vecs[i].b, q, r, z, lat);
         check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
         check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
         check($sformatf("vec%0d_div_by_zero", i), 32'(z), 32'(vecs[i].z));
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Back-pressure: the result must hold, and new requests must be ignored.
      in_valid = 1'b1;
      dividend = 8'd200;
      divisor  = 4'd13;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         dividend = 8'd50 + 8'(c);
         divisor  = 4'd3;
         tick();
         check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
         check($sformatf("bp%0d_quotient", c), 32'(quotient), 32'd15);
         check($sformatf("bp%0d_remainder", c), 32'(remainder), 32'd5);
         check($sformatf("bp%0d_div_by_zero", c), 32'(div_by_zero), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      $display("backpressure: handshake done, out_valid=%0d in_ready=%0d q=%0d", out_valid, in_ready, quotient);
      check("bp_hs_out_valid", 32'(out_valid), 32'd0);
      check("bp_hs_in_ready", 32'(in_ready), 32'd1);
      check("bp_hs_quotient_kept", 32'(quotient), 32'd15);
      check("bp_hs_remainder_kept", 32'(remainder), 32'd5);

      // Abort by reset during CALC.
      in_valid = 1'b1;
      dividend = 8'd200;
      divisor  = 4'd7;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      $display("abort: out_valid=%0d q=%0d r=%0d dbz=%0d", out_valid, quotient, remainder, div_by_zero);
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_quotient", 32'(quotient), 32'd0);
      check("abort_remainder", 32'(remainder), 32'd0);
      check("abort_div_by_zero", 32'(div_by_zero), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      do_op(8'd9, 4'd2, q, r, z, lat);
      $display("after abort: 9 / 2 -> q=%0d r=%0d lat=%0d", q, r, lat);
      check("post_abort_quotient", 32'(q), 32'd4);
      check("post_abort_remainder", 32'(r), 32'd1);
      check("post_abort_latency", 32'(lat), 32'd8);

      // Loopback: the 4x4 product divided by b gives back a with no remainder.
      for (int a = 1; a <= 15; a++) begin
         for (int b = 1; b <= 15; b++) begin
            ra = 8'(a * b);
            do_op(ra, 4'(b), q, r, z, lat);
            $display("loop: %0d / %0d -> q=%0d r=%0d", ra, b, q, r);
            check($sformatf("loop_%0dx%0d_q", a, b), 32'(q), 32'(a));
            check($sformatf("loop_%0dx%0d_r", a, b), 32'(r), 32'd0);
         end
      end

      // Random operations against a reference model.
      for (int k = 0; k < 1000; k++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 4'($urandom_range(0, 15));
         if (rb == 4'd0) begin
            eq = 8'hFF;
            er = 4'd0;
            ez = 1'b1;
         end else begin
            eq = ra / {4'd0, rb};
            er = 4'(ra % {4'd0, rb});
            ez = 1'b0;
         end
         do_op(ra, rb, q, r, z, lat);
         $display("rand %0d: %0d / %0d -> q=%0d r=%0d dbz=%0d", k, ra, rb, q, r, z);
         check("rand_quotient", 32'(q), 32'(eq));
         check("rand_remainder", 32'(r), 32'(er));
         check("rand_div_by_zero", 32'(z), 32'(ez));
         check("rand_latency", 32'(lat), ez ? 32'd0 : 32'd8);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
